ntt_coeff_unloader: RTL and testbench
=====================================

Name: ntt_coeff_unloader

Overview:
Drain side of the NTT datapath. It captures the 64-coefficient parallel result array of the ntt core in one cycle, then streams the coefficients out one per beat on a valid/ready interface. The downstream consumer is a result file-dump monitor in sim, or a memory writer in the system. It mirrors the array loading done on the ntt input side.

Parameters:
N, 64, number of coefficients per polynomial; must be a power of two, minimum 2.
W, 64, coefficient width in bits.
IW, $clog2(N), index width; derived, not overridden.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
load  input  1  capture request; single-cycle pulse or level.
x_in  input  N x W (unpacked [0:N-1])  parallel coefficient array from the ntt core.
busy  output  1  high from the cycle after capture until done is deasserted.
out_valid  output  1  output beat valid.
out_ready  input  1  consumer ready.
out_data  output  W  coefficient value.
out_idx  output  IW  coefficient index of the current beat.
out_last  output  1  high on the beat for the final coefficient.
done  output  1  one-cycle pulse after the final handshake.

Behaviour:
- Reset (rst low, async): state=IDLE. busy=0, out_valid=0, out_data=0, out_idx=0, out_last=0, done=0. The capture buffer is cleared to 0.
- States:
  - IDLE: when load=1 at a clock edge, register all N coefficients and go to STREAM. Otherwise stay in IDLE.
  - STREAM: out_valid=1. out_data=buf[order(cnt)]. out_idx=order(cnt). out_last=(cnt==N-1).
    - A handshake is out_valid & out_ready at a clock edge; it increments cnt.
    - A handshake with cnt==N-1 goes to DONE and sets cnt=0.
  - DONE: done=1 and out_valid=0 for exactly one cycle, then go to IDLE.
- Latency: load sampled at edge t -> out_valid=1 with index 0 after edge t (visible in cycle t+1).
- Throughput: 1 coefficient per cycle while out_ready is held high. N coefficients take N cycles, plus 1 DONE cycle.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_idx and out_last hold stable. out_valid never drops mid-stream.
- busy=1 in STREAM and DONE.
- load while busy is ignored; the buffer is not overwritten. Capture happens only in IDLE.
- load=1 held continuously: a new capture occurs on the first IDLE cycle after DONE. There are no back-to-back frames without a gap cycle.
- x_in is sampled only on the capture edge. Later changes to x_in do not affect the stream in progress.
- Counter: cnt is IW bits and saturates by state transition only. No wrap-around is visible on out_idx beyond N-1.
- Reset mid-stream returns to IDLE immediately: out_valid=0 asynchronously and no done pulse. The consumer must discard the partial frame.
- order(cnt)=cnt (natural order) unless the optional feature is enabled.

Optional Feature:
- Macro NTT_UNLOAD_BITREV_EN.
- Defined: order(cnt) = bit-reverse of cnt over IW bits, so the NTT's bit-reversed output emerges in natural spectral order. out_idx still reports the buffer index actually read (the bit-reversed value). out_last is still tied to cnt==N-1.
- Undefined: natural order, and no reversal logic is synthesized.

Decomposition:
- Shared package ntt_pkg:
  - localparams NTT_N=64 and NTT_W=64.
  - typedef coeff_t as logic [NTT_W-1:0].
  - typedef coeff_arr_t for the N-entry array.
  - enum unload_state_e {IDLE, STREAM, DONE}.
  - Function bitrev(idx, width).
- No sub-module is needed. The bit-reverse is a package function, not an instance.

Test Plan:
1. Reset then idle: rst low for 3 cycles, then high with load=0 -> all outputs 0, busy=0, no done for 20 cycles.
2. Basic stream: x_in[i]=64'h1000+i, load pulse, out_ready=1 -> 64 beats with out_data=64'h1000..64'h103F and idx 0..63. out_last only on beat 63. done is high exactly one cycle after beat 63.
3. Backpressure: same data, out_ready toggling 1,0,0,1 -> each beat repeats while out_ready=0 with data held stable. Total 64 unique beats, no drops or duplicates.
4. Load while busy: start a stream, change x_in to all 64'hFFFF_FFFF_FFFF_FFFF, pulse load at beat 10 -> remaining beats still 64'h100A..64'h103F.
5. Reset mid-stream: assert rst at beat 30 -> out_valid=0 immediately and no done pulse. After release, a new load with x_in[i]=i streams 0..63 from idx 0.
6. With NTT_UNLOAD_BITREV_EN and x_in[i]=i -> beat k has out_data=out_idx=bitrev6(k): beat 1 gives 32, beat 2 gives 16, beat 63 gives 63.

Source files
------------

// File: rtl/ntt_pkg.sv
// ntt_pkg
// Shared definitions for the NTT drain path: default polynomial geometry,
// coefficient types, the unloader state encoding and an index bit-reverse
// helper used when the stream must be reordered.
// No ports (package).

package ntt_pkg;

   localparam int NTT_N = 64;
   localparam int NTT_W = 64;

   typedef logic [NTT_W-1:0] coeff_t;
   typedef coeff_t coeff_arr_t [0:NTT_N-1];

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } unload_state_e;

   // Reverses the low 'width' bits of idx; higher result bits are zero.
   function automatic logic [31:0] bitrev(input logic [31:0] idx, input int width);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < width; i++) begin
         r[i] = idx[width-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/ntt_coeff_unloader_if.sv
// ntt_coeff_unloader_if
// Valid/ready coefficient stream leaving the NTT unloader.
// Signals:
//   out_valid  beat valid (producer)
//   out_ready  consumer ready (consumer)
//   out_data   coefficient value, W bits (producer)
//   out_idx    buffer index of the current beat, $clog2(N) bits (producer)
//   out_last   final beat of the frame (producer)
// Modports: master = producer (unloader), slave = consumer.

interface ntt_coeff_unloader_if
   import ntt_pkg::*;
#(
   parameter int N = NTT_N,
   parameter int W = NTT_W
);

   localparam int IW = $clog2(N);

   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [IW-1:0] out_idx;
   logic          out_last;

   modport master (
      output out_valid,
      output out_data,
      output out_idx,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_idx,
      input  out_last,
      output out_ready
   );

endinterface

// File: rtl/ntt_coeff_unloader.sv
// ntt_coeff_unloader
// Drain side of the NTT datapath. Captures the whole N-coefficient result
// array in one cycle, then streams it out one coefficient per handshake and
// pulses done for one cycle after the final beat.
// Ports:
//   clk    system clock, rising edge
//   rst    asynchronous active-low reset
//   load   capture request (pulse or level), honoured only when idle
//   x_in   parallel coefficient array [0:N-1] of W-bit values
//   busy   high while streaming and during the done cycle
//   done   one-cycle pulse after the final handshake
//   ob     coefficient stream (ntt_coeff_unloader_if.master)
// Configuration macro: NTT_UNLOAD_BITREV_EN
//   defined   -> beat k reads buffer entry bitrev(k), turning the NTT's
//                bit-reversed output into natural spectral order
//   undefined -> natural order, no reversal logic

module ntt_coeff_unloader
   import ntt_pkg::*;
#(
   parameter int N = NTT_N,
   parameter int W = NTT_W
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [W-1:0]  x_in [0:N-1],
   output logic          busy,
   output logic          done,
   ntt_coeff_unloader_if.master ob
);

   localparam int IW = $clog2(N);
   localparam logic [IW-1:0] LAST_CNT = IW'(N-1);

   unload_state_e state;
   logic [IW-1:0] cnt;
   logic [IW-1:0] cnt_next;
   logic [W-1:0]  cap_buf [0:N-1];

   // Maps a beat number to the buffer entry read on that beat.
   function automatic logic [IW-1:0] order(input logic [IW-1:0] c);
`ifdef NTT_UNLOAD_BITREV_EN
      return IW'(bitrev(32'(c), IW));
`else
      return c;
`endif
   endfunction

   assign cnt_next = cnt + IW'(1);

   // Single state machine; all stream outputs are registered and are
   // precomputed for the next beat on each handshake, so they stay stable
   // while the consumer stalls. The final handshake goes straight to DONE,
   // so cnt never wraps onto out_idx.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         cnt          <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         ob.out_valid <= 1'b0;
         ob.out_data  <= '0;
         ob.out_idx   <= '0;
         ob.out_last  <= 1'b0;
         for (int i = 0; i < N; i++) begin
            cap_buf[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (load) begin
                  for (int i = 0; i < N; i++) begin
                     cap_buf[i] <= x_in[i];
                  end
                  state        <= STREAM;
                  cnt          <= '0;
                  busy         <= 1'b1;
                  ob.out_valid <= 1'b1;
                  ob.out_data  <= x_in[order('0)];
                  ob.out_idx   <= order('0);
                  ob.out_last  <= 1'b0;
               end
            end

            STREAM: begin
               if (ob.out_ready) begin
                  if (cnt == LAST_CNT) begin
                     state        <= DONE;
                     cnt          <= '0;
                     done         <= 1'b1;
                     ob.out_valid <= 1'b0;
                     ob.out_data  <= '0;
                     ob.out_idx   <= '0;
                     ob.out_last  <= 1'b0;
                  end else begin
                     cnt          <= cnt_next;
                     ob.out_data  <= cap_buf[order(cnt_next)];
                     ob.out_idx   <= order(cnt_next);
                     ob.out_last  <= (cnt_next == LAST_CNT);
                  end
               end
            end

            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end

            default: begin
               state        <= IDLE;
               busy         <= 1'b0;
               done         <= 1'b0;
               ob.out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ntt_coeff_unloader.sv
// tb_ntt_coeff_unloader
// Directed self-checking bench for ntt_coeff_unloader (N=64, W=64).
// Inputs are driven and outputs sampled on the falling clock edge.
// Follows NTT_UNLOAD_BITREV_EN for the expected read order.

module tb_ntt_coeff_unloader;

   localparam int N = 64;
   localparam int W = 64;

   logic          clk;
   logic          rst;
   logic          load;
   logic [W-1:0]  x_in [0:N-1];
   logic          busy;
   logic          done;
   logic [W-1:0]  frame [0:N-1];

   int checks;
   int errors;

   ntt_coeff_unloader_if #(.N(N), .W(W)) ifc ();

   ntt_coeff_unloader #(.N(N), .W(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .x_in (x_in),
      .busy (busy),
      .done (done),
      .ob   (ifc.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected buffer index read on beat k.
   function automatic logic [5:0] exp_idx(input int k);
      logic [5:0] kk;
      kk = k[5:0];
`ifdef NTT_UNLOAD_BITREV_EN
      return {kk[0], kk[1], kk[2], kk[3], kk[4], kk[5]};
`else
      return kk;
`endif
   endfunction

   task automatic set_frame(input logic [W-1:0] base);
      for (int i = 0; i < N; i++) begin
         x_in[i]  = base + W'(i);
         frame[i] = base + W'(i);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      load = 1'b0;
      ifc.out_ready = 1'b0;
      set_frame(64'h0);
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, ifc.out_valid, ifc.out_last, ifc.out_idx, ifc.out_data} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_state: got busy=%b done=%b valid=%b last=%b idx=%0d data=%h, want all 0",
                  busy, done, ifc.out_valid, ifc.out_last, ifc.out_idx, ifc.out_data);
      end
      rst = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         checks++;
         if ({busy, done, ifc.out_valid, ifc.out_last, ifc.out_idx, ifc.out_data} !== '0) begin
            errors++;
            $display("[TB] FAIL idle_cycle%0d: got busy=%b done=%b valid=%b, want 0 0 0",
                     c, busy, done, ifc.out_valid);
         end
      end
   endtask

   // Checks beat k at the current falling edge.
   task automatic check_beat(input string name, input int k);
      checks++;
      if (ifc.out_valid !== 1'b1 || ifc.out_data !== frame[exp_idx(k)] ||
          ifc.out_idx !== exp_idx(k) || ifc.out_last !== (k == N-1) ||
          busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s beat%0d: got valid=%b data=%h idx=%0d last=%b busy=%b done=%b, want 1 %h %0d %b 1 0",
                  name, k, ifc.out_valid, ifc.out_data, ifc.out_idx, ifc.out_last, busy, done,
                  frame[exp_idx(k)], exp_idx(k), (k == N-1));
      end
   endtask

   // At the falling edge after the final handshake: done cycle, then idle.
   task automatic check_done(input string name);
      checks++;
      if (done !== 1'b1 || ifc.out_valid !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL %s done_pulse: got done=%b valid=%b busy=%b, want 1 0 1",
                  name, done, ifc.out_valid, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || ifc.out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s after_done: got done=%b busy=%b valid=%b, want 0 0 0",
                  name, done, busy, ifc.out_valid);
      end
   endtask

   task automatic test_basic_stream;
      set_frame(64'h1000);
      ifc.out_ready = 1'b1;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      for (int k = 0; k < N; k++) begin
         check_beat("basic", k);
         @(negedge clk);
      end
      check_done("basic");
   endtask

   task automatic test_backpressure;
      logic pat [0:3];
      int k;
      int cyc;
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      set_frame(64'h1000);
      load = 1'b1;
      ifc.out_ready = 1'b0;
      @(negedge clk);
      load = 1'b0;
      k = 0;
      cyc = 0;
      while (k < N && cyc < 400) begin
         check_beat("bp", k);
         ifc.out_ready = pat[cyc % 4];
         @(negedge clk);
         if (pat[cyc % 4]) k++;
         cyc++;
      end
      checks++;
      if (k != N) begin
         errors++;
         $display("[TB] FAIL bp_beat_count: got %0d beats, want %0d", k, N);
      end
      ifc.out_ready = 1'b1;
      check_done("bp");
   endtask

   task automatic test_load_while_busy;
      set_frame(64'h1000);
      ifc.out_ready = 1'b1;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      for (int k = 0; k < N; k++) begin
         check_beat("ldbusy", k);
         if (k == 10) begin
            for (int i = 0; i < N; i++) x_in[i] = 64'hFFFF_FFFF_FFFF_FFFF;
            load = 1'b1;
         end else begin
            load = 1'b0;
         end
         @(negedge clk);
      end
      check_done("ldbusy");
   endtask

   task automatic test_reset_mid_stream;
      set_frame(64'h1000);
      ifc.out_ready = 1'b1;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      for (int k = 0; k < 30; k++) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (ifc.out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midrst_async: got valid=%b busy=%b, want 0 0", ifc.out_valid, busy);
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (c == 1) rst = 1'b1;
         checks++;
         if (done !== 1'b0 || ifc.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_nodone%0d: got done=%b valid=%b, want 0 0", c, done, ifc.out_valid);
         end
      end
      set_frame(64'h0);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      for (int k = 0; k < N; k++) begin
         check_beat("midrst", k);
         @(negedge clk);
      end
      check_done("midrst");
   endtask

   task automatic test_order_points;
      logic [5:0] want1, want2, want63;
`ifdef NTT_UNLOAD_BITREV_EN
      want1 = 6'd32; want2 = 6'd16; want63 = 6'd63;
`else
      want1 = 6'd1;  want2 = 6'd2;  want63 = 6'd63;
`endif
      set_frame(64'h0);
      ifc.out_ready = 1'b1;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (k == 1 || k == 2 || k == 63) begin
            checks++;
            if (ifc.out_idx !== (k == 1 ? want1 : k == 2 ? want2 : want63) ||
                ifc.out_data !== W'(k == 1 ? want1 : k == 2 ? want2 : want63)) begin
               errors++;
               $display("[TB] FAIL order_beat%0d: got idx=%0d data=%0d, want %0d", k,
                        ifc.out_idx, ifc.out_data, (k == 1 ? want1 : k == 2 ? want2 : want63));
            end
         end
         @(negedge clk);
      end
      check_done("order");
   endtask

   task automatic test_back_to_back;
      set_frame(64'h2000);
      ifc.out_ready = 1'b1;
      load = 1'b1;
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
         check_beat("b2b1", k);
         @(negedge clk);
      end
      checks++;
      if (done !== 1'b1 || ifc.out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_done: got done=%b valid=%b, want 1 0", done, ifc.out_valid);
      end
      @(negedge clk);
      checks++;
      if (ifc.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_gap: got valid=%b busy=%b done=%b, want 0 0 0", ifc.out_valid, busy, done);
      end
      set_frame(64'h3000);
      @(negedge clk);
      load = 1'b0;
      for (int k = 0; k < N; k++) begin
         check_beat("b2b2", k);
         @(negedge clk);
      end
      check_done("b2b2");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic_stream();
      test_backpressure();
      test_load_while_busy();
      test_reset_mid_stream();
      test_order_points();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
